// File: rtl/mul64_seq_pkg.sv
// rtl/mul64_seq_pkg.sv - shared constants and state encoding for the sequential multiplier
package mul64_seq_pkg;

    localparam int MUL_W     = 64;
    localparam int MUL_CNT_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul64_seq_if.sv
// rtl/mul64_seq_if.sv - start/busy/done request interface of the multiplier
interface mul64_seq_if;
    import mul64_seq_pkg::*;

    logic                 start;
    logic [MUL_W-1:0]     a;
    logic [MUL_W-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*MUL_W-1:0]   product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);

endinterface

// File: rtl/mul64_seq_add64.sv
// rtl/mul64_seq_add64.sv - Add64 carry-lookahead adder, 4-bit groups with lookahead across groups
module add64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout,
    output logic        pg,
    output logic        gg
);
    localparam int GRP  = 4;
    localparam int NGRP = 16;

    logic [63:0]     g;
    logic [63:0]     p;
    logic [NGRP-1:0] grp_g;
    logic [NGRP-1:0] grp_p;
    logic [NGRP:0]   grp_c;
    logic            c;
    logic            gg_acc;

    always_comb begin
        g      = a & b;
        p      = a ^ b;
        grp_g  = '0;
        grp_p  = '1;
        grp_c  = '0;
        sum    = '0;
        c      = 1'b0;
        gg_acc = 1'b0;

        for (int k = 0; k < NGRP; k++) begin
            for (int i = 0; i < GRP; i++) begin
                grp_g[k] = g[k*GRP+i] | (p[k*GRP+i] & grp_g[k]);
                grp_p[k] = grp_p[k] & p[k*GRP+i];
            end
        end

        grp_c[0] = cin;
        for (int k = 0; k < NGRP; k++) begin
            grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
            gg_acc     = grp_g[k] | (grp_p[k] & gg_acc);
        end

        // Each group only ripples internally from its looked-ahead carry-in.
        for (int k = 0; k < NGRP; k++) begin
            c = grp_c[k];
            for (int i = 0; i < GRP; i++) begin
                sum[k*GRP+i] = p[k*GRP+i] ^ c;
                c = g[k*GRP+i] | (p[k*GRP+i] & c);
            end
        end

        cout = grp_c[NGRP];
        pg   = &p;
        gg   = gg_acc;
    end

endmodule

// File: rtl/mul64_seq.sv
// rtl/mul64_seq.sv - iterative 64x64->128 shift-add multiplier around one Add64
module mul64_seq
    import mul64_seq_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    mul64_seq_if.slave  bus
);
    if (WIDTH != MUL_W) begin : g_width_check
        $error("mul64_seq: WIDTH must be 64");
    end

    state_t                 state, state_next;
    logic [MUL_W-1:0]       acc, acc_next;
    logic [MUL_W-1:0]       mcand, mcand_next;
    logic [MUL_W-1:0]       mplier, mplier_next;
    logic [MUL_CNT_W-1:0]   count, count_next;
    logic [2*MUL_W-1:0]     product, product_next;

    logic [MUL_W-1:0]       add_sum;
    logic                   add_cout;
    logic [MUL_W:0]         partial;
    logic [2*MUL_W-1:0]     shifted;
    logic                   bypass;

    add64 u_add64 (
        .a    (acc),
        .b    (mcand),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout),
        .pg   (),
        .gg   ()
    );

    // The 65-bit partial sum keeps the adder's carry as the new top bit.
    always_comb begin
        partial = mplier[0] ? {add_cout, add_sum} : {1'b0, acc};
        shifted = {partial, mplier[MUL_W-1:1]};
        bypass  = ZERO_BYPASS && ((bus.a == '0) || (bus.b == '0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            state   <= state_next;
            acc     <= acc_next;
            mcand   <= mcand_next;
            mplier  <= mplier_next;
            count   <= count_next;
            product <= product_next;
        end
    end

    always_comb begin
        state_next   = state;
        acc_next     = acc;
        mcand_next   = mcand;
        mplier_next  = mplier;
        count_next   = count;
        product_next = product;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                bus.done   = (state == ST_DONE);
                state_next = ST_IDLE;
                if (bus.start) begin
                    state_next = ST_RUN;
                    acc_next   = '0;
                    if (bypass) begin
                        // Zeroed operands parked on the last iteration: one cycle, product 0.
                        mcand_next  = '0;
                        mplier_next = '0;
                        count_next  = MUL_CNT_W'(MUL_W - 1);
                    end else begin
                        mcand_next  = bus.a;
                        mplier_next = bus.b;
                        count_next  = '0;
                    end
                end
            end
            ST_RUN: begin
                bus.busy    = 1'b1;
                acc_next    = shifted[2*MUL_W-1:MUL_W];
                mplier_next = shifted[MUL_W-1:0];
                count_next  = count + 1'b1;
                if (count == MUL_CNT_W'(MUL_W - 1)) begin
                    product_next = shifted;
                    state_next   = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.product = product;

endmodule

// File: tb/tb_mul64_seq.sv
// tb/tb_mul64_seq.sv - directed self-checking bench for mul64_seq (bypass and non-bypass builds)
module tb_mul64_seq;
    import mul64_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mul64_seq_if bus1();
    mul64_seq_if bus0();

    mul64_seq #(.WIDTH(64), .ZERO_BYPASS(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    mul64_seq #(.WIDTH(64), .ZERO_BYPASS(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic st, input logic [63:0] x, input logic [63:0] y);
        if (sel) begin
            bus0.start = st; bus0.a = x; bus0.b = y;
        end else begin
            bus1.start = st; bus1.a = x; bus1.b = y;
        end
    endtask

    function automatic logic get_done(input bit sel);
        return sel ? bus0.done : bus1.done;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? bus0.busy : bus1.busy;
    endfunction

    function automatic logic [127:0] get_product(input bit sel);
        return sel ? bus0.product : bus1.product;
    endfunction

    // Accept at E0, then count cycles until done is seen (bounded).
    task automatic run_op(input bit sel, input logic [63:0] x, input logic [63:0] y,
                          output int cyc, output int busy_cyc);
        drive(sel, 1'b1, x, y);
        step();
        drive(sel, 1'b0, 64'($urandom), 64'($urandom));
        cyc = 0;
        busy_cyc = 0;
        while (!get_done(sel) && cyc < 200) begin
            if (get_busy(sel)) busy_cyc++;
            step();
            cyc++;
        end
    endtask

    int cyc, bc, cyc2, dones;
    logic prod_ok;
    logic [63:0] ones;

    initial begin
        ones = '1;
        drive(1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, '0, '0);
        rst_n = 1'b0;
        step();
        step();
        check("reset_busy", 128'(bus1.busy), 128'd0);
        check("reset_done", 128'(bus1.done), 128'd0);
        check("reset_product", bus1.product, 128'd0);
        check("reset_product_nb", bus0.product, 128'd0);
        rst_n = 1'b1;
        step();

        run_op(1'b0, ones, ones, cyc, bc);
        check("max_cycles", 128'(cyc), 128'd64);
        check("max_busy_cycles", 128'(bc), 128'd64);
        check("max_product", get_product(1'b0), 128'hffff_ffff_ffff_fffe_0000_0000_0000_0001);
        step();
        check("max_done_width", 128'(bus1.done), 128'd0);

        run_op(1'b0, 64'd3, 64'd5, cyc, bc);
        check("small_product", bus1.product, 128'h0f);
        step();

        run_op(1'b0, 64'h1_0000_0000, 64'h1_0000_0000, cyc, bc);
        check("cross_product", bus1.product, {64'd1, 64'd0});
        step();

        run_op(1'b0, 64'h0123_4567_89ab_cdef, 64'd1, cyc, bc);
        check("ident_product", bus1.product, {64'd0, 64'h0123_4567_89ab_cdef});
        step();

        run_op(1'b0, 64'd0, 64'hdead_beef, cyc, bc);
        check("bypass_a0_cycles", 128'(cyc), 128'd1);
        check("bypass_a0_product", bus1.product, 128'd0);
        step();
        check("bypass_done_width", 128'(bus1.done), 128'd0);

        run_op(1'b0, 64'd7, 64'd9, cyc, bc);
        step();
        run_op(1'b0, 64'd5, 64'd0, cyc, bc);
        check("bypass_b0_cycles", 128'(cyc), 128'd1);
        check("bypass_b0_product", bus1.product, 128'd0);
        step();

        run_op(1'b1, 64'd3, 64'd5, cyc, bc);
        check("nb_small_product", bus0.product, 128'd15);
        step();
        run_op(1'b1, 64'd0, 64'hdead_beef, cyc, bc);
        check("nb_zero_cycles", 128'(cyc), 128'd64);
        check("nb_zero_product", bus0.product, 128'd0);
        step();

        // Second start during RUN must be ignored.
        drive(1'b0, 1'b1, 64'd2, 64'd3);
        step();
        drive(1'b0, 1'b0, 64'd0, 64'd0);
        cyc = 0;
        dones = 0;
        repeat (10) begin step(); cyc++; end
        drive(1'b0, 1'b1, 64'd7, 64'd7);
        step();
        cyc++;
        drive(1'b0, 1'b0, ones, ones);
        while (!bus1.done && cyc < 200) begin step(); cyc++; end
        check("ignore_cycles", 128'(cyc), 128'd64);
        check("ignore_product", bus1.product, 128'd6);
        repeat (4) begin
            if (bus1.done) dones++;
            step();
        end
        check("ignore_single_done", 128'(dones), 128'd1);

        // Back-to-back: start held, operands switched while in DONE.
        drive(1'b0, 1'b1, 64'd2, 64'd3);
        step();
        cyc = 0;
        while (!bus1.done && cyc < 200) begin step(); cyc++; end
        check("b2b_first_cycles", 128'(cyc), 128'd64);
        check("b2b_first_product", bus1.product, 128'd6);
        drive(1'b0, 1'b1, 64'd4, 64'd4);
        step();
        drive(1'b0, 1'b0, 64'd0, 64'd0);
        cyc2 = 1;
        prod_ok = 1'b1;
        while (!bus1.done && cyc2 < 200) begin
            if (bus1.product !== 128'd6) prod_ok = 1'b0;
            step();
            cyc2++;
        end
        check("b2b_spacing", 128'(cyc2), 128'd65);
        check("b2b_held_product", 128'(prod_ok), 128'd1);
        check("b2b_second_product", bus1.product, 128'd16);
        step();

        // Reset in the middle of RUN abandons the operation.
        drive(1'b0, 1'b1, 64'd9, 64'd9);
        step();
        drive(1'b0, 1'b0, 64'd0, 64'd0);
        repeat (30) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_busy", 128'(bus1.busy), 128'd0);
        check("midrst_done", 128'(bus1.done), 128'd0);
        check("midrst_product", bus1.product, 128'd0);
        dones = 0;
        repeat (70) begin
            if (bus1.done) dones++;
            step();
        end
        check("midrst_no_done", 128'(dones), 128'd0);
        run_op(1'b0, 64'd9, 64'd9, cyc, bc);
        check("midrst_after_cycles", 128'(cyc), 128'd64);
        check("midrst_after_product", bus1.product, 128'd81);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
